// File: rtl/merger5_pkg.sv
// merger5_pkg: shared widths, port-index helpers and tag encoding for the 5-way round-robin merger.
package merger5_pkg;
  localparam int NUM_PORTS = 5;
  localparam int TAG_W = 5;
  localparam int PTR_W = 3;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PTR_W-1:0] idx_t;
  localparam idx_t PTR_RST = 3'd4;
  function automatic tag_t onehot5(input idx_t idx);
    return (idx < 3'(NUM_PORTS)) ? tag_t'(1) << idx : '0;
  endfunction
  function automatic idx_t wrap5(input int v);
    return idx_t'(v % NUM_PORTS);
  endfunction
endpackage

// File: rtl/merger5_rr_if.sv
// merger5_rr_if: five producer drive/free channels plus one consumer channel.
// Carries o_err only when MERGER5_ERRCHK_EN is defined.
interface merger5_rr_if #(parameter int DATA_WIDTH = 32);
  logic i_drive0, i_drive1, i_drive2, i_drive3, i_drive4;
  logic [DATA_WIDTH-1:0] i_data0, i_data1, i_data2, i_data3, i_data4;
  logic o_free0, o_free1, o_free2, o_free3, o_free4;
  logic o_driveNext;
  logic [DATA_WIDTH+4:0] o_data;
  logic i_freeNext;
`ifdef MERGER5_ERRCHK_EN
  logic o_err;
  modport slave (
    input  i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
    input  i_data0, i_data1, i_data2, i_data3, i_data4, i_freeNext,
    output o_free0, o_free1, o_free2, o_free3, o_free4, o_driveNext, o_data, o_err
  );
  modport master (
    output i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
    output i_data0, i_data1, i_data2, i_data3, i_data4, i_freeNext,
    input  o_free0, o_free1, o_free2, o_free3, o_free4, o_driveNext, o_data, o_err
  );
`else
  modport slave (
    input  i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
    input  i_data0, i_data1, i_data2, i_data3, i_data4, i_freeNext,
    output o_free0, o_free1, o_free2, o_free3, o_free4, o_driveNext, o_data
  );
  modport master (
    output i_drive0, i_drive1, i_drive2, i_drive3, i_drive4,
    output i_data0, i_data1, i_data2, i_data3, i_data4, i_freeNext,
    input  o_free0, o_free1, o_free2, o_free3, o_free4, o_driveNext, o_data
  );
`endif
endinterface

// File: rtl/merger5_rr_arb5.sv
// rr_arb5: combinational round-robin pick, searching ptr+1..ptr+5 mod 5.
module rr_arb5
  import merger5_pkg::*;
(
  input  logic [NUM_PORTS-1:0] pend,
  input  idx_t                 ptr,
  output tag_t                 gnt,
  output idx_t                 gnt_idx
);
  // Walk the search order backwards so the earliest pending port is the last write.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--)
      if (pend[wrap5(int'(ptr) + i)]) begin
        gnt_idx = wrap5(int'(ptr) + i);
        gnt = onehot5(gnt_idx);
      end
  end
endmodule

// File: rtl/merger5_rr.sv
// merger5_rr: 5-to-1 round-robin merge of pulse-handshake words into {one-hot tag, payload}.
// Define MERGER5_ERRCHK_EN to add a sticky o_err for protocol violations.
module merger5_rr
  import merger5_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rstn,
  merger5_rr_if.slave bus
);
  typedef struct packed {
    tag_t                  tag;
    logic [DATA_WIDTH-1:0] payload;
  } word_t;
  logic [NUM_PORTS-1:0]  drv, cap, pend_q, pend_d;
  logic [DATA_WIDTH-1:0] din [NUM_PORTS];
  logic [DATA_WIDTH-1:0] hold_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] hold_d [NUM_PORTS];
  idx_t  ptr_q, ptr_d, gnt_idx;
  tag_t  gnt, free_q, free_d;
  word_t word_q, word_d;
  logic  full_q, full_d, dnext_q, dnext_d, open, take;
  assign drv = {bus.i_drive4, bus.i_drive3, bus.i_drive2, bus.i_drive1, bus.i_drive0};
  assign din[0] = bus.i_data0;
  assign din[1] = bus.i_data1;
  assign din[2] = bus.i_data2;
  assign din[3] = bus.i_data3;
  assign din[4] = bus.i_data4;
  rr_arb5 u_arb (
    .pend    (pend_q),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );
  // A re-drive while still pending is dropped so the held word survives.
  always_comb begin
    open = !full_q || bus.i_freeNext;
    take = open && |pend_q;
    cap = drv & ~pend_q;
    pend_d = (pend_q & ~(take ? gnt : '0)) | cap;
    for (int k = 0; k < NUM_PORTS; k++) hold_d[k] = cap[k] ? din[k] : hold_q[k];
    ptr_d = take ? gnt_idx : ptr_q;
    full_d = take || (full_q && !bus.i_freeNext);
    word_d = take ? word_t'{tag: gnt, payload: hold_q[gnt_idx]} : word_q;
    free_d = take ? gnt : '0;
    dnext_d = take;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      hold_q <= '{default: '0};
      ptr_q <= PTR_RST;
      full_q <= 1'b0;
      word_q <= '0;
      free_q <= '0;
      dnext_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      full_q <= full_d;
      word_q <= word_d;
      free_q <= free_d;
      dnext_q <= dnext_d;
    end
  end
  assign bus.o_free0 = free_q[0];
  assign bus.o_free1 = free_q[1];
  assign bus.o_free2 = free_q[2];
  assign bus.o_free3 = free_q[3];
  assign bus.o_free4 = free_q[4];
  assign bus.o_driveNext = dnext_q;
  assign bus.o_data = word_q;
`ifdef MERGER5_ERRCHK_EN
  logic err_q, err_d;
  always_comb err_d = err_q || |(drv & pend_q) || (bus.i_freeNext && !full_q);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_merger5_rr.sv
// tb_merger5_rr: randomized and directed checks of merger5_rr against a spec-level model and a per-port scoreboard.
module tb_merger5_rr;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic drv [5];
  logic [DW-1:0] dat [5];
  logic fnext;
  int tests = 0;
  int fails = 0;
  merger5_rr_if #(.DATA_WIDTH(DW)) bus ();
  merger5_rr #(.DATA_WIDTH(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  assign bus.i_drive0 = drv[0];
  assign bus.i_drive1 = drv[1];
  assign bus.i_drive2 = drv[2];
  assign bus.i_drive3 = drv[3];
  assign bus.i_drive4 = drv[4];
  assign bus.i_data0 = dat[0];
  assign bus.i_data1 = dat[1];
  assign bus.i_data2 = dat[2];
  assign bus.i_data3 = dat[3];
  assign bus.i_data4 = dat[4];
  assign bus.i_freeNext = fnext;
  wire [4:0] fvec = {bus.o_free4, bus.o_free3, bus.o_free2, bus.o_free1, bus.o_free0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending flags, held words, last winner and slot occupancy.
  bit m_pend [5];
  logic [DW-1:0] m_hold [5];
  int m_ptr = 4;
  bit m_full = 0;
  logic [DW+4:0] m_data = '0;
  logic [4:0] m_free = '0;
  bit m_dn = 0;
  bit m_err = 0;
  int glog [$];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 5; k++) begin
        m_pend[k] = 0;
        m_hold[k] = '0;
      end
      m_ptr = 4;
      m_full = 0;
      m_data = '0;
      m_free = '0;
      m_dn = 0;
      m_err = 0;
    end else begin : step
      int g;
      bit cap [5];
      g = -1;
      if (!m_full || fnext)
        for (int i = 1; i <= 5; i++)
          if (g < 0 && m_pend[(m_ptr + i) % 5]) g = (m_ptr + i) % 5;
      for (int k = 0; k < 5; k++) begin
        cap[k] = drv[k] && !m_pend[k];
        if (drv[k] && m_pend[k]) m_err = 1;
      end
      if (fnext && !m_full) m_err = 1;
      if (g >= 0) begin
        m_data = {5'(1 << g), m_hold[g]};
        m_full = 1;
        m_pend[g] = 0;
        m_ptr = g;
        m_free = 5'(1 << g);
        m_dn = 1;
        glog.push_back(g);
      end else begin
        m_free = '0;
        m_dn = 0;
        if (fnext) m_full = 0;
      end
      for (int k = 0; k < 5; k++)
        if (cap[k]) begin
          m_pend[k] = 1;
          m_hold[k] = dat[k];
        end
    end
  end

  always @(negedge clk) begin
    chk("o_data", bus.o_data, m_data);
    chk("o_free", fvec, m_free);
    chk("o_driveNext", bus.o_driveNext, m_dn);
`ifdef MERGER5_ERRCHK_EN
    chk("o_err", bus.o_err, m_err);
`endif
  end

  // Scoreboard: each accepted word must come out once, tagged with its port, in per-port order.
  typedef struct {int p; logic [DW-1:0] d;} sb_t;
  sb_t sbq [$];
  bit busy [5];

  task automatic clear_tb();
    for (int k = 0; k < 5; k++) begin
      drv[k] = 0;
      busy[k] = 0;
    end
    fnext = 0;
    sbq.delete();
  endtask

  task automatic do_reset();
    rstn = 0;
    clear_tb();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  // fmode: 0 free in the cycle of o_driveNext, 1 withhold, 2 force free, 3 random
  task automatic cycle(input logic [4:0] d, input int fmode);
    int t;
    bit hit;
    for (int k = 0; k < 5; k++) if (fvec[k]) busy[k] = 0;
    for (int k = 0; k < 5; k++) begin
      drv[k] = d[k];
      if (d[k] && !busy[k]) begin
        busy[k] = 1;
        sbq.push_back('{p: k, d: dat[k]});
      end
    end
    fnext = fmode == 0 ? bus.o_driveNext : fmode == 2 ? 1'b1 : fmode == 3 ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    if (bus.o_driveNext) begin
      t = -1;
      for (int k = 0; k < 5; k++) if (bus.o_data[DW+k]) t = k;
      hit = 0;
      for (int i = 0; i < sbq.size() && !hit; i++)
        if (sbq[i].p == t) begin
          chk("sb_payload", bus.o_data[DW-1:0], sbq[i].d);
          sbq.delete(i);
          hit = 1;
        end
      if (!hit) begin
        tests++;
        fails++;
        $display("FAIL sb_orphan: word %0h delivered with nothing queued for it", bus.o_data);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation ran out of time");
    $fatal(1);
  end

  initial begin
    int n0, fcnt [5];
    logic [DW-1:0] w1, w4;
    logic [DW+4:0] held;
    int act;
    for (int k = 0; k < 5; k++) dat[k] = '0;
    clear_tb();
    #1 rstn = 0;
    repeat (2) @(negedge clk);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_o_free", fvec, 0);
    chk("rst_o_driveNext", bus.o_driveNext, 0);
    rstn = 1;

    dat[2] = 32'hA5A5_0001;
    cycle(5'b00100, 1);
    chk("single_early", bus.o_driveNext, 0);
    cycle(5'b00000, 1);
    chk("single_dn", bus.o_driveNext, 1);
    chk("single_free", fvec, 5'b00100);
    chk("single_data", bus.o_data, {5'b00100, 32'hA5A5_0001});
    cycle(5'b00000, 1);
    cycle(5'b00000, 2);

    do_reset();
    for (int k = 0; k < 5; k++) begin
      dat[k] = 32'(k * 32'h11);
      fcnt[k] = 0;
    end
    cycle(5'b11111, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(5'b00000, 0);
      chk("all5_dn", bus.o_driveNext, 1);
      chk("all5_word", bus.o_data, {5'(1 << i), 32'(i * 32'h11)});
      for (int k = 0; k < 5; k++) fcnt[k] += int'(fvec[k]);
    end
    cycle(5'b00000, 0);
    for (int k = 0; k < 5; k++) fcnt[k] += int'(fvec[k]);
    for (int k = 0; k < 5; k++) chk("all5_free_once", fcnt[k], 1);

    do_reset();
    n0 = glog.size();
    dat[0] = $urandom;
    dat[3] = $urandom;
    cycle(5'b01001, 0);
    for (int c = 0; c < 60 && glog.size() - n0 < 20; c++) begin
      dat[0] = $urandom;
      dat[3] = $urandom;
      cycle({1'b0, fvec[3], 2'b00, fvec[0]}, 0);
    end
    chk("fair_count", 32'(glog.size() - n0 >= 20), 1);
    for (int i = 0; i < 20 && n0 + i < glog.size(); i++)
      chk("fair_order", glog[n0 + i], (i % 2 == 0) ? 0 : 3);

    do_reset();
    w1 = $urandom;
    w4 = $urandom;
    dat[1] = w1;
    dat[4] = w4;
    cycle(5'b10010, 1);
    cycle(5'b00000, 1);
    chk("bp_first", bus.o_data, {5'b00010, w1});
    held = bus.o_data;
    for (int i = 0; i < 10; i++) begin
      cycle(5'b00000, 1);
      chk("bp_hold", bus.o_data, held);
      chk("bp_no_dn", bus.o_driveNext, 0);
      chk("bp_no_free4", bus.o_free4, 0);
    end
    cycle(5'b00000, 2);
    chk("bp_next_dn", bus.o_driveNext, 1);
    chk("bp_next_free4", bus.o_free4, 1);
    chk("bp_next_word", bus.o_data, {5'b10000, w4});
    cycle(5'b00000, 2);

    do_reset();
    for (int k = 0; k < 5; k++) dat[k] = $urandom;
    cycle(5'b00111, 1);
    cycle(5'b00000, 1);
    cycle(5'b00001, 1);
    #2 rstn = 0;
    clear_tb();
    #1;
    chk("rst_mid_data", bus.o_data, 0);
    chk("rst_mid_free", fvec, 0);
    chk("rst_mid_dn", bus.o_driveNext, 0);
    repeat (2) @(negedge clk);
    rstn = 1;
    act = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(5'b00000, 0);
      act += int'(bus.o_driveNext) + int'(|fvec);
    end
    chk("rst_mid_stale", act, 0);

`ifdef MERGER5_ERRCHK_EN
    do_reset();
    chk("err_reset", bus.o_err, 0);
    dat[1] = 32'h0000_0111;
    cycle(5'b00010, 1);
    dat[1] = 32'h0000_0222;
    cycle(5'b00010, 1);
    chk("err_set", bus.o_err, 1);
    chk("err_orig_payload", bus.o_data, {5'b00010, 32'h0000_0111});
    cycle(5'b00000, 2);
    repeat (3) cycle(5'b00000, 0);
    chk("err_sticky", bus.o_err, 1);
`endif

    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [4:0] d;
      for (int k = 0; k < 5; k++) begin
        dat[k] = $urandom;
        d[k] = (!busy[k] || fvec[k]) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      end
      cycle(d, 3);
    end
    clear_tb();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
